// File: rtl/conv_sched.sv
`default_nettype none
// ============================================================================
// Module      : conv_sched
// Description : Window scheduler for one convolution layer. Tracks pixel
//               raster position, detects complete KxK windows and sequences
//               load -> CIM compute -> function readout per window.
// Revision    : 1.0  initial release
// ============================================================================
module conv_sched #(
    parameter int  img_width  = 28,
    parameter int  kernel_dim = 3,
    localparam int out_dim    = img_width - kernel_dim + 1,
    localparam int WIN_N      = out_dim * out_dim,
    localparam int WIN_W      = (WIN_N > 1) ? $clog2(WIN_N) : 1,
    localparam int PIX_W      = (img_width > 1) ? $clog2(img_width) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ibuf_we,
    input  logic             i_ctrl_busy,
    input  logic             i_cim_busy,
    input  logic             i_func_busy,
    input  logic             i_next_busy,
    output logic             o_busy,
    output logic             o_ctrl_start,
    output logic             o_cim_start,
    output logic             o_func_start,
    output logic [WIN_W-1:0] o_win_idx,
    output logic             o_frame_done,
    output logic             o_err
);

    localparam logic [PIX_W-1:0] c_last_pix  = PIX_W'(img_width - 1);
    localparam logic [PIX_W-1:0] c_first_win = PIX_W'(kernel_dim - 1);
    localparam logic [WIN_W-1:0] c_last_win  = WIN_W'(WIN_N - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_START = 3'd1,
        S_LOAD_WAIT  = 3'd2,
        S_CIM_START  = 3'd3,
        S_CIM_WAIT   = 3'd4,
        S_FUNC_REQ   = 3'd5,
        S_FUNC_WAIT  = 3'd6
    } state_t;

    state_t           r_state;
    logic [PIX_W-1:0] r_row;
    logic [PIX_W-1:0] r_col;
    logic [WIN_W-1:0] r_win_cnt;
    logic             r_pending;

    logic w_accept;
    logic w_win_event;
    logic w_func_exit;
    logic w_enter_load;
    logic w_pending_nxt;
    logic w_busy_nxt;

    assign w_accept    = i_ibuf_we && !o_busy;
    assign w_win_event = w_accept && (r_row >= c_first_win) && (r_col >= c_first_win);

    // The function unit raises busy only after its start pulse, so the
    // start cycle itself is not allowed to end FUNC_WAIT.
    assign w_func_exit   = (r_state == S_FUNC_WAIT) && !o_func_start && !i_func_busy;
    assign w_enter_load  = (r_pending || w_win_event) && ((r_state == S_IDLE) || w_func_exit);
    assign w_pending_nxt = w_enter_load ? 1'b0 : (r_pending || w_win_event);

    // Busy is computed from next-state values so it is visible in the same
    // cycle as the load start.
    assign w_busy_nxt = w_enter_load
                     || (r_state == S_LOAD_START)
                     || ((r_state == S_LOAD_WAIT) && i_ctrl_busy)
                     || w_pending_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_win_cnt    <= '0;
            r_pending    <= 1'b0;
            o_busy       <= 1'b0;
            o_ctrl_start <= 1'b0;
            o_cim_start  <= 1'b0;
            o_func_start <= 1'b0;
            o_win_idx    <= '0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_ctrl_start <= 1'b0;
            o_cim_start  <= 1'b0;
            o_func_start <= 1'b0;
            o_frame_done <= 1'b0;
            r_pending    <= w_pending_nxt;
            o_busy       <= w_busy_nxt;

            if (i_ibuf_we && o_busy) begin
                o_err <= 1'b1;
            end

            if (w_accept) begin
                if (r_col == c_last_pix) begin
                    r_col <= '0;
                    r_row <= (r_row == c_last_pix) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if (w_enter_load) begin
                o_ctrl_start <= 1'b1;
                o_win_idx    <= r_win_cnt;
                r_win_cnt    <= (r_win_cnt == c_last_win) ? '0 : r_win_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_enter_load) r_state <= S_LOAD_START;
                end
                S_LOAD_START: r_state <= S_LOAD_WAIT;
                S_LOAD_WAIT: begin
                    if (!i_ctrl_busy) begin
                        r_state     <= S_CIM_START;
                        o_cim_start <= 1'b1;
                    end
                end
                S_CIM_START: r_state <= S_CIM_WAIT;
                S_CIM_WAIT: begin
                    if (!i_cim_busy) r_state <= S_FUNC_REQ;
                end
                S_FUNC_REQ: begin
                    if (!i_next_busy) begin
                        r_state      <= S_FUNC_WAIT;
                        o_func_start <= 1'b1;
                    end
                end
                S_FUNC_WAIT: begin
                    if (w_func_exit) begin
                        r_state      <= w_enter_load ? S_LOAD_START : S_IDLE;
                        o_frame_done <= (o_win_idx == c_last_win);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
